// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port sync data RAM between the RV32I core
// data port and the AES memory master with round-robin arbitration.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  core request (byte address), held until done
//   cpu_rdata         read data to core, valid in the core's done cycle
//   cpu_stall         freezes core while its request is outstanding
//   cpu_err           sticky flag: core issued a misaligned access
//   aes_req/we/addr/wdata  AES request (word address), held until aes_done
//   aes_done          one-cycle completion pulse for AES, aes_rdata valid
//   mem_en/we/addr/wdata   RAM command port
//   mem_rdata         RAM read data, one cycle after mem_en
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    input  logic              aes_req,
    input  logic              aes_we,
    input  logic [ADDR_W-1:0] aes_addr,
    input  logic [DATA_W-1:0] aes_wdata,
    output logic              aes_done,
    output logic [DATA_W-1:0] aes_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISS_CPU,
        DONE_CPU,
        ISS_AES,
        DONE_AES
    } state_t;

    state_t state;
    state_t state_nx;

    // 1 when AES held the last grant; resets to 1 so the core wins first.
    logic last_aes;

    logic              cpu_mis;
    logic [ADDR_W-1:0] cpu_word;
    logic              addr_unused;

    assign cpu_mis  = (cpu_addr[1:0] != 2'b00);
    assign cpu_word = cpu_addr[ADDR_W+1:2];

    // Byte-address bits above the RAM window are deliberately ignored.
    assign addr_unused = ^cpu_addr[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_aes <= 1'b1;
            cpu_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ISS_CPU) begin
                last_aes <= 1'b0;
                if (cpu_mis)
                    cpu_err <= 1'b1;
            end
            if (state == ISS_AES)
                last_aes <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        aes_rdata = '0;
        aes_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req && aes_req)
                    state_nx = last_aes ? ISS_CPU : ISS_AES;
                else if (cpu_req)
                    state_nx = ISS_CPU;
                else if (aes_req)
                    state_nx = ISS_AES;
            end
            ISS_CPU: begin
                // A misaligned access never reaches the RAM.
                mem_en    = !cpu_mis;
                mem_we    = cpu_we && !cpu_mis;
                mem_addr  = cpu_word;
                mem_wdata = cpu_wdata;
                state_nx  = DONE_CPU;
            end
            DONE_CPU: begin
                if (!cpu_mis)
                    cpu_rdata = mem_rdata;
                state_nx = aes_req ? ISS_AES : IDLE;
            end
            ISS_AES: begin
                mem_en    = 1'b1;
                mem_we    = aes_we;
                mem_addr  = aes_addr;
                mem_wdata = aes_wdata;
                state_nx  = DONE_AES;
            end
            DONE_AES: begin
                aes_rdata = mem_rdata;
                aes_done  = 1'b1;
                state_nx  = cpu_req ? ISS_CPU : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req && (state != DONE_CPU);

endmodule
